ex_mdu: RTL and testbench



---
 rtl/ex_mdu.sv | 244 ++++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV64M multiply/divide unit sitting beside the EX-stage ALU.
// Shift-add multiply and restoring divide on operand magnitudes, one step per cycle,
// with a sign fix-up folded into the last step. Divide-by-zero and signed overflow
// finish in a single cycle.
// Optional build macro MDU_FAST_MUL_EN: all multiplies use a single-cycle combinational
// multiplier and skip CALC; divides stay iterative.
module ex_mdu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [3:0]         op_i,
    input  logic [XLEN-1:0]    rs1_i,
    input  logic [XLEN-1:0]    rs2_i,
    input  logic [RFIDX_W-1:0] rd_idx_i,
    input  logic               kill_i,
    output logic               stall_req_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    result_o,
    output logic [RFIDX_W-1:0] rd_idx_o
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(32);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    // Sign-extend a 32-bit W result to XLEN.
    function automatic logic [XLEN-1:0] w_ext(input logic [31:0] x);
        return {{(XLEN-32){x[31]}}, x};
    endfunction

    // Apply product sign and pick the half (or W word) the op returns.
    function automatic logic [XLEN-1:0] mul_fix(input logic [2*XLEN-1:0] mag,
                                                input logic neg, input logic is_low,
                                                input logic is_w);
        logic [2*XLEN-1:0] p;
        p = neg ? -mag : mag;
        if (is_w) begin
            // Reserved W multiplies (funct3 001-011) return zero.
            return is_low ? w_ext(p[31:0]) : '0;
        end
        return is_low ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Quotient negated on differing signs, remainder follows the dividend.
    function automatic logic [XLEN-1:0] div_fix(input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] r,
                                                input logic neg_q, input logic neg_r,
                                                input logic is_rem, input logic is_w);
        logic [XLEN-1:0] x;
        x = is_rem ? (neg_r ? -r : r) : (neg_q ? -q : q);
        return is_w ? w_ext(x[31:0]) : x;
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_w_q;
    logic [2:0]       fn_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvsr_q;

    // Start-time operand decode, valid whenever EX presents an instruction.
    logic            st_w;
    logic [2:0]      st_fn;
    logic            st_div;
    logic            st_a_sgn;
    logic            st_b_sgn;
    logic            st_a_neg;
    logic            st_b_neg;
    logic            st_dz;
    logic            st_ovf;
    logic [XLEN-1:0] st_a;
    logic [XLEN-1:0] st_b;
    logic [XLEN-1:0] st_a_mag;
    logic [XLEN-1:0] st_b_mag;
    logic [XLEN-1:0] st_min;
    logic [XLEN-1:0] st_special;

    // Decode op, narrow W operands, take magnitudes and resolve the divide special cases.
    always_comb begin
        st_w     = op_i[3];
        st_fn    = op_i[2:0];
        st_div   = st_fn[2];
        st_a_sgn = st_div ? ~st_fn[0] : (~st_w & ((st_fn == 3'b001) | (st_fn == 3'b010)));
        st_b_sgn = st_div ? ~st_fn[0] : (~st_w & (st_fn == 3'b001));
        if (st_w) begin
            st_a   = st_a_sgn ? w_ext(rs1_i[31:0]) : {{(XLEN-32){1'b0}}, rs1_i[31:0]};
            st_b   = st_b_sgn ? w_ext(rs2_i[31:0]) : {{(XLEN-32){1'b0}}, rs2_i[31:0]};
            st_min = {{(XLEN-31){1'b1}}, 31'd0};
        end else begin
            st_a   = rs1_i;
            st_b   = rs2_i;
            st_min = {1'b1, {(XLEN-1){1'b0}}};
        end
        st_a_neg   = st_a_sgn & st_a[XLEN-1];
        st_b_neg   = st_b_sgn & st_b[XLEN-1];
        st_a_mag   = st_a_neg ? -st_a : st_a;
        st_b_mag   = st_b_neg ? -st_b : st_b;
        st_dz      = st_div & (st_b == '0);
        st_ovf     = st_div & st_a_sgn & (st_a == st_min) & (st_b == '1);
        if (st_dz) begin
            st_special = st_fn[1] ? st_a : '1;
        end else begin
            st_special = st_fn[1] ? '0 : st_a;
        end
        if (st_w) begin
            st_special = w_ext(st_special[31:0]);
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, st_a_mag} * {{XLEN{1'b0}}, st_b_mag};
`endif

    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] mcand_nx;
    logic [XLEN-1:0]   mplier_nx;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;

    // One shift-add step and one restoring-divide step; CALC commits whichever the op needs.
    always_comb begin
        acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_nx  = mcand_q << 1;
        mplier_nx = mplier_q >> 1;
        rem_sh    = {rem_q, quo_q[XLEN-1]};
        quo_nx    = quo_q << 1;
        if (rem_sh >= {1'b0, dvsr_q}) begin
            rem_nx    = XLEN'(rem_sh - {1'b0, dvsr_q});
            quo_nx[0] = 1'b1;
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
        end
    end

    // Combinational so the instruction is held in EX in the same cycle it is accepted.
    assign stall_req_o = ((state_q == StIdle) & start_i & ~kill_i) | (state_q == StCalc);

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_w_q   <= 1'b0;
            fn_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_idx_o <= '0;
        end else if (kill_i) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        rd_idx_o <= rd_idx_i;
                        is_w_q   <= st_w;
                        fn_q     <= st_fn;
                        a_neg_q  <= st_a_neg;
                        b_neg_q  <= st_b_neg;
                        busy_o   <= 1'b1;
                        if (st_dz | st_ovf) begin
                            result_o <= st_special;
                            done_o   <= 1'b1;
                            state_q  <= StDone;
`ifdef MDU_FAST_MUL_EN
                        end else if (!st_div) begin
                            result_o <= mul_fix(fast_prod, st_a_neg ^ st_b_neg,
                                                st_fn == 3'b000, st_w);
                            done_o   <= 1'b1;
                            state_q  <= StDone;
`endif
                        end else begin
                            cnt_q    <= st_w ? CNT_WORD : CNT_FULL;
                            acc_q    <= '0;
                            mcand_q  <= {{XLEN{1'b0}}, st_a_mag};
                            mplier_q <= st_b_mag;
                            rem_q    <= '0;
                            // W dividends start in the upper word so MSB-first shifting sees them.
                            quo_q    <= st_w ? (st_a_mag << 32) : st_a_mag;
                            dvsr_q   <= st_b_mag;
                            state_q  <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q    <= acc_nx;
                    mcand_q  <= mcand_nx;
                    mplier_q <= mplier_nx;
                    rem_q    <= rem_nx;
                    quo_q    <= quo_nx;
                    cnt_q    <= cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        if (fn_q[2]) begin
                            result_o <= div_fix(quo_nx, rem_nx, a_neg_q ^ b_neg_q, a_neg_q,
                                                fn_q[1], is_w_q);
                        end else begin
                            result_o <= mul_fix(acc_nx, a_neg_q ^ b_neg_q, fn_q == 3'b000,
                                                is_w_q);
                        end
                        done_o  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // start_i is ignored here; the next instruction arrives in IDLE.
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: stimulus pushes expected results, a monitor pops on done_o.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [63:0] rs1_i = '0;
    logic [63:0] rs2_i = '0;
    logic [4:0]  rd_idx_i = '0;
    logic        kill_i = 1'b0;
    logic        stall_req_o;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_idx_o;

    ex_mdu #(.XLEN(64), .RFIDX_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_idx_i    (rd_idx_i),
        .kill_i      (kill_i),
        .stall_req_o (stall_req_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .result_o    (result_o),
        .rd_idx_o    (rd_idx_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          issue;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } vec_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stall_cnt = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // RV64M semantics in plain arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic signed [127:0] pa, pb, pp;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         ua32, ub32, r32;
        sa = a; sb = b;
        ua32 = a[31:0]; ub32 = b[31:0];
        sa32 = a[31:0]; sb32 = b[31:0];
        if (!op[3]) begin
            case (op[2:0])
                3'd0: begin pa = {64'd0, a}; pb = {64'd0, b}; pp = pa * pb; return pp[63:0]; end
                3'd1: begin
                    pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pp = pa * pb;
                    return pp[127:64];
                end
                3'd2: begin
                    pa = {{64{a[63]}}, a}; pb = {64'd0, b}; pp = pa * pb;
                    return pp[127:64];
                end
                3'd3: begin pa = {64'd0, a}; pb = {64'd0, b}; pp = pa * pb; return pp[127:64]; end
                3'd4: begin
                    if (b == 0) return ONES;
                    if (a == MIN64 && b == ONES) return a;
                    return sa / sb;
                end
                3'd5: return (b == 0) ? ONES : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (a == MIN64 && b == ONES) return 64'd0;
                    return sa % sb;
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (op[2:0])
            3'd0: r32 = ua32 * ub32;
            3'd4: begin
                if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                else r32 = sa32 / sb32;
            end
            3'd5: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ua32 / ub32;
            3'd6: begin
                if (ub32 == 0) r32 = ua32;
                else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
                else r32 = sa32 % sb32;
            end
            3'd7: r32 = (ub32 == 0) ? ua32 : ua32 % ub32;
            default: r32 = 32'd0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int lat_of(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic w, zero, ovf;
        w = op[3];
        if (op[2]) begin
            zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
            ovf  = ~op[0] & (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                               : (a == MIN64 && b == ONES));
            if (zero || ovf) return 1;
        end
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return ONES;
            2: return MIN64;
            3: return 64'hFFFF_FFFF_8000_0000;
            4: return 64'd1;
            5: return {$urandom, 32'hFFFF_FFFF};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy_o) begin
            tests++; fails++;
            $display("FAIL wait_idle: busy_o still %b after %0d cycles, required 0", busy_o, n);
        end
    endtask

    // Present one instruction for a single cycle in IDLE.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input bit push, input logic [63:0] res);
        exp_t e;
        wait_idle();
        op_i = op; rs1_i = a; rs2_i = b; rd_idx_i = rd; start_i = 1'b1;
        if (push) begin
            e.res = res; e.rd = rd; e.issue = cyc; e.lat = lat_of(op, a, b);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Monitor: counts stall cycles and scores every done_o pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || kill_i) stall_cnt = 0;
            else if (stall_req_o) stall_cnt++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: result %h with nothing outstanding", result_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result_o, e.res);
                    check("rd_idx", 64'(rd_idx_o), 64'(e.rd));
                    check("latency", 64'(cyc - e.issue), 64'(e.lat));
                    check("stall_cycles", 64'(stall_cnt), 64'(e.lat));
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t dir[9];

    initial begin
        int n;
        logic [3:0]  rop;
        logic [63:0] ra, rb;
        dir[0] = '{4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        dir[1] = '{4'h3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE};
        dir[2] = '{4'h2, ONES, 64'd2, ONES};
        dir[3] = '{4'h4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA};
        dir[4] = '{4'h6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE};
        dir[5] = '{4'hD, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000};
        dir[6] = '{4'h4, 64'd5, 64'd0, ONES};
        dir[7] = '{4'h6, MIN64, ONES, 64'd0};
        dir[8] = '{4'hC, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000};

        // Reset state.
        #12;
        check("reset_stall", 64'(stall_req_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_rd", 64'(rd_idx_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            issue(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), 1'b1, dir[i].r);
        end

        // A start presented during DONE must be ignored.
        issue(4'h5, 64'd100, 64'd7, 5'd12, 1'b1, 64'd14);
        n = 0;
        while (!done_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(done_o), 64'd1);
        op_i = 4'h0; rs1_i = 64'd1; rs2_i = 64'd1; rd_idx_i = 5'd13; start_i = 1'b1;
        #1;
        check("stall_in_done", 64'(stall_req_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("start_ignored_in_done", 64'(busy_o), 64'd0);

        // Kill mid-divide: back to IDLE, no done, result held.
        issue(4'h5, 64'hFFFF_0000_1234_5678, 64'd3, 5'd9, 1'b0, 64'd0);
        repeat (9) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill_busy", 64'(busy_o), 64'd0);
        check("kill_done", 64'(done_o), 64'd0);
        check("kill_result_held", result_o, 64'd14);
        // kill_i wins over start_i in IDLE.
        op_i = 4'h4; rs1_i = 64'd9; rs2_i = 64'd2; start_i = 1'b1; kill_i = 1'b1;
        #1;
        check("stall_with_kill", 64'(stall_req_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0; kill_i = 1'b0;
        check("kill_over_start", 64'(busy_o), 64'd0);
        issue(4'h7, 64'd100, 64'd7, 5'd11, 1'b1, 64'd2);

        // Asynchronous reset during CALC.
        issue(4'h1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd21, 1'b0, 64'd0);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_stall", 64'(stall_req_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_rd", 64'(rd_idx_o), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'h8, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd22, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);

        // Randomized back-to-back traffic against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = pick();
            rb = pick();
            issue(rop, ra, rb, 5'($urandom), 1'b1, model(rop, ra, rb));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
